seq_adder: RTL and testbench



---
 rtl/seq_adder_if.sv | 26 ++
 rtl/seq_adder.sv | 130 +++++++++++++
 tb/tb_seq_adder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_adder_if.sv
// seq_adder_if: start/done handshake, operand and result bundle for seq_adder.
// master = requester (drives operands), slave = the adder.
interface seq_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock,
// carry kept in a register between slices. Reports carry-out and signed overflow.
// Optional feature macro: SEQ_ADDER_SUB_EN (honour the sub input; default add-only).
module seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic        clk,
    input  logic        rst,
    seq_adder_if.slave  bus
);
    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // effective B' (already inverted for subtract)
    logic             carry_q;
    logic [CW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE-1:0] a_sl_c;
    logic [SLICE-1:0] b_sl_c;
    logic [SLICE-1:0] res_c;
    logic [SLICE:0]   ext_c;
    logic             carry_d;
    logic             ovf_d;
    logic             last_c;

`ifdef SEQ_ADDER_SUB_EN
`else
    // sub is part of the shared bus but has no function in the add-only build
    logic unused_sub;
    assign unused_sub = bus.sub;
`endif

    // Slice k adder: select operand slices, add with carry, derive MSB overflow
    always_comb begin
        a_sl_c = '0;
        b_sl_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == CW'(i)) begin
                a_sl_c = a_q[i*SLICE +: SLICE];
                b_sl_c = b_q[i*SLICE +: SLICE];
            end
        end
        ext_c   = {1'b0, a_sl_c} + {1'b0, b_sl_c} + (SLICE+1)'(carry_q);
        res_c   = ext_c[SLICE-1:0];
        carry_d = ext_c[SLICE];
        // carry into the MSB recovered from the MSB's own sum bit
        ovf_d   = (a_sl_c[SLICE-1] ^ b_sl_c[SLICE-1] ^ res_c[SLICE-1]) ^ carry_d;
        last_c  = (k_q == CW'(N - 1));
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q <= bus.a;
`ifdef SEQ_ADDER_SUB_EN
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
`else
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
`endif
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (k_q == CW'(i)) begin
                            sum_q[i*SLICE +: SLICE] <= res_c;
                        end
                    end
                    carry_q <= carry_d;
                    k_q     <= k_q + CW'(1);
                    if (last_c) begin
                        cout_q  <= carry_d;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed + randomized checks of seq_adder against an
// arithmetic reference model; also sweeps SLICE=1 and SLICE=16 instances.
module tb_seq_adder;
`ifdef SEQ_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int NS = 4;   // slices in the main instance (16/4)

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_adder_if #(.WIDTH(16)) m_if ();
    seq_adder_if #(.WIDTH(16)) s1_if ();
    seq_adder_if #(.WIDTH(16)) s16_if ();

    seq_adder #(.WIDTH(16), .SLICE(4))  dut     (.clk(clk), .rst(rst), .bus(m_if));
    seq_adder #(.WIDTH(16), .SLICE(1))  dut_s1  (.clk(clk), .rst(rst), .bus(s1_if));
    seq_adder #(.WIDTH(16), .SLICE(16)) dut_s16 (.clk(clk), .rst(rst), .bus(s16_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word two's-complement arithmetic
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, output logic [15:0] s, output logic co,
                         output logic ov);
        logic [15:0] bp;
        logic        c;
        logic [16:0] full;
        bp   = (SUB_EN && sb) ? ~b : b;
        c    = (SUB_EN && sb) ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, bp} + {16'd0, c};
        s    = full[15:0];
        co   = full[16];
        ov   = (a[15] == bp[15]) && (full[15] != a[15]);
    endtask

    // Called just after the accepting edge; counts cycles until done (bounded)
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!m_if.done && lat < 100) begin
            if (m_if.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb);
        logic [15:0] es;
        logic        ec, eo;
        logic [15:0] held;
        int          lat, bcnt;
        model(a, b, ci, sb, es, ec, eo);
        m_if.a = a; m_if.b = b; m_if.cin = ci; m_if.sub = sb; m_if.start = 1'b1;
        @(posedge clk); #1;
        m_if.start = 1'b0;
        m_if.a = 16'($urandom); m_if.b = 16'($urandom);
        m_if.cin = 1'($urandom); m_if.sub = 1'($urandom);
        wait_done(lat, bcnt);
        chk({tag, "_lat"},  32'(lat),  32'(NS));
        chk({tag, "_busy"}, 32'(bcnt), 32'(NS));
        chk({tag, "_sum"},  32'(m_if.sum),  32'(es));
        chk({tag, "_cout"}, 32'(m_if.cout), 32'(ec));
        chk({tag, "_ovf"},  32'(m_if.ovf),  32'(eo));
        held = m_if.sum;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(m_if.done), 32'd0);
        chk({tag, "_sum_hold"},   32'(m_if.sum),  32'(held));
    endtask

    initial begin
        int          lat, bcnt, dcnt;
        int          lat1, lat16;
        logic [15:0] sum1, sum16;
        logic        c1, c16;
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        m_if.start = 1'b0;  m_if.a = '0;  m_if.b = '0;  m_if.cin = 1'b0;  m_if.sub = 1'b0;
        s1_if.start = 1'b0; s1_if.a = '0; s1_if.b = '0; s1_if.cin = 1'b0; s1_if.sub = 1'b0;
        s16_if.start = 1'b0; s16_if.a = '0; s16_if.b = '0; s16_if.cin = 1'b0; s16_if.sub = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(m_if.busy), 32'd0);
        chk("rst_done", 32'(m_if.done), 32'd0);
        chk("rst_sum",  32'(m_if.sum),  32'd0);
        chk("rst_cout", 32'(m_if.cout), 32'd0);
        chk("rst_ovf",  32'(m_if.ovf),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_op("d_basic", 16'h1234, 16'h1111, 1'b0, 1'b0);
        chk("d_basic_const", 32'(m_if.sum), 32'h2345);
        run_op("d_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("d_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("d_ovf_const", 32'(m_if.ovf), 32'd1);
        run_op("d_sub",   16'h0005, 16'h0007, 1'b1, 1'b1);
        chk("d_sub_const", 32'(m_if.sum), SUB_EN ? 32'hFFFE : 32'h000D);

        // start during RUN is ignored
        m_if.a = 16'h0001; m_if.b = 16'h0002; m_if.cin = 1'b0; m_if.sub = 1'b0; m_if.start = 1'b1;
        @(posedge clk); #1;
        m_if.start = 1'b0;
        @(posedge clk); #1;
        m_if.a = 16'hAAAA; m_if.b = 16'h5555; m_if.start = 1'b1;
        @(posedge clk); #1;
        m_if.start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_lat", 32'(lat), 32'(NS - 2));
        chk("ign_sum", 32'(m_if.sum), 32'h0003);
        @(posedge clk); #1;
        run_op("ign_next", 16'h0100, 16'h0023, 1'b1, 1'b0);

        // Reset two cycles into RUN aborts without a done pulse
        m_if.a = 16'h8888; m_if.b = 16'h8888; m_if.cin = 1'b1; m_if.sub = 1'b0; m_if.start = 1'b1;
        @(posedge clk); #1;
        m_if.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(m_if.busy), 32'd0);
        chk("abort_done", 32'(m_if.done), 32'd0);
        chk("abort_sum",  32'(m_if.sum),  32'd0);
        chk("abort_cout", 32'(m_if.cout), 32'd0);
        chk("abort_ovf",  32'(m_if.ovf),  32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (m_if.done || m_if.busy) dcnt++;
        end
        chk("abort_quiet", 32'(dcnt), 32'd0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_op("rnd", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        run_op("rnd_edge", 16'h8000, 16'h8000, 1'b0, 1'b0);

        // Parameter sweep: SLICE=1 and SLICE=16
        s1_if.a = 16'hFFFF; s1_if.b = 16'h0001; s1_if.start = 1'b1;
        s16_if.a = 16'hFFFF; s16_if.b = 16'h0001; s16_if.start = 1'b1;
        @(posedge clk); #1;
        s1_if.start = 1'b0; s16_if.start = 1'b0;
        lat1 = -1; lat16 = -1; sum1 = 16'hDEAD; sum16 = 16'hDEAD; c1 = 1'b0; c16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (s1_if.done && lat1 < 0) begin
                lat1 = k; sum1 = s1_if.sum; c1 = s1_if.cout;
            end
            if (s16_if.done && lat16 < 0) begin
                lat16 = k; sum16 = s16_if.sum; c16 = s16_if.cout;
            end
        end
        chk("sw1_lat",   32'(lat1),  32'd16);
        chk("sw1_sum",   32'(sum1),  32'h0000);
        chk("sw1_cout",  32'(c1),    32'd1);
        chk("sw16_lat",  32'(lat16), 32'd1);
        chk("sw16_sum",  32'(sum16), 32'h0000);
        chk("sw16_cout", 32'(c16),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
